write_back_stage: RTL
=====================

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter RA_W, default 5, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  MEM stage presents a retiring instruction.
REQ-006 in_ready  output  1  stage can accept; high only in IDLE.
REQ-007 in_sel  input  2  result source: 00 ALU, 01 MEM load, 10 PC+4, 11 immediate (LUI).
REQ-008 in_alu, in_pc4, in_imm  input  XLEN each  candidate results.
REQ-009 in_rd  input  RA_W  destination register.
REQ-010 in_we  input  1  instruction writes the register file.
REQ-011 in_funct3  input  3  load type, used only when in_sel=01.
REQ-012 in_addr_lo  input  3  load byte offset (bits [2:0] of the address; bit 2 ignored when XLEN=32).
REQ-013 mem_rsp_valid  input  1  load data valid this cycle.
REQ-014 mem_rsp_data  input  XLEN  raw aligned memory word.
REQ-015 flush  input  1  kill the pending or presented instruction.
REQ-016 rf_we  output  1  register write strobe, one-cycle pulse.
REQ-017 rf_waddr  output  RA_W  write address, registered.
REQ-018 rf_wdata  output  XLEN  write data, registered.
REQ-019 busy  output  1  high in WAIT_MEM.

Function
REQ-020 States SHALL be IDLE and WAIT_MEM only.
REQ-021 Accept SHALL occur when in_valid=1, in_ready=1, flush=0.
REQ-022 Non-load accept (in_sel!=01): next cycle rf_we=in_we AND (in_rd!=0), rf_waddr=in_rd, rf_wdata=selected source; state stays IDLE; latency 1 cycle.
REQ-023 Load accept with mem_rsp_valid=1 in the same cycle: write next cycle (latency 1), state stays IDLE.
REQ-024 Load accept with mem_rsp_valid=0: latch rd, we, funct3, addr_lo; go to WAIT_MEM.
REQ-025 In WAIT_MEM with mem_rsp_valid=1 and flush=0: write formatted data next cycle; return to IDLE.
REQ-026 Load formatting: 000 LB, 001 LH, 010 LW sign-extended; 100 LBU, 101 LHU, 110 LWU zero-extended; 011 LD full word (XLEN=64 only); any other code passes mem_rsp_data unmodified.
REQ-027 Byte lane = addr_lo for byte loads, addr_lo[2:1] halfword lane, addr_lo[2] word lane (XLEN=64); misaligned offsets use the lane containing the lowest addressed byte, truncated to alignment.
REQ-028 For XLEN=32, LW, LWU and LD all return the full word.
REQ-029 rd=0 SHALL suppress rf_we but state transitions proceed normally.
REQ-030 flush SHALL have priority: in IDLE it blocks accept; in WAIT_MEM it returns to IDLE with no write, discarding any same-cycle mem_rsp_valid.
REQ-031 mem_rsp_valid in IDLE without a same-cycle load accept SHALL be ignored.
REQ-032 rf_waddr and rf_wdata SHALL hold their last values while rf_we=0.

Reset
REQ-033 rst=1 SHALL force IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0 on the next edge, overriding accept and mem_rsp_valid; in_ready=1 after the reset edge.
REQ-034 Reset during WAIT_MEM SHALL discard the pending load with no write.

Verification
REQ-035 ALU op: in_sel=00, in_alu=0x0000_1234, rd=5, we=1 -> next cycle rf_we=1, waddr=5, wdata=0x0000_1234.
REQ-036 Delayed load: LB, addr_lo=3, rd=7; mem_rsp_valid after 3 cycles with data 0x80FF_0000 -> busy=1 and in_ready=0 for 3 cycles, then rf_we=1, wdata=0xFFFF_FF80.
REQ-037 Same-cycle LHU: addr_lo=2, data 0xBEEF_1234 -> next cycle wdata=0x0000_BEEF.
REQ-038 rd=0: in_sel=10, in_pc4=0x104 -> rf_we stays 0.
REQ-039 Flush in WAIT_MEM coincident with mem_rsp_valid -> no rf_we, state IDLE, in_ready=1 next cycle.
REQ-040 XLEN=64 LW: addr_lo=4, data 0x8000_0001_0000_0002 -> wdata=0xFFFF_FFFF_8000_0001.

Source files
------------

// File: rtl/write_back_stage_if.sv
// Bundle between the MEM stage, the write-back stage and the register file.
// The master side drives the retiring instruction and load response; the slave side is the stage.
interface write_back_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_sel;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_imm;
  logic [RA_W-1:0] in_rd;
  logic            in_we;
  logic [2:0]      in_funct3;
  logic [2:0]      in_addr_lo;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            flush;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;

  modport master (
    output in_valid, in_sel, in_alu, in_pc4, in_imm, in_rd, in_we,
           in_funct3, in_addr_lo, mem_rsp_valid, mem_rsp_data, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  in_valid, in_sel, in_alu, in_pc4, in_imm, in_rd, in_we,
           in_funct3, in_addr_lo, mem_rsp_valid, mem_rsp_data, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: selects the result source, formats load data and issues a
// one-cycle register-file write; waits in WAIT_MEM for late load responses.
module write_back_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic            clk,
  input logic            rst,
  write_back_stage_if.slave wb
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [2:0] LANE_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

  state_t          state_q, state_d;
  logic [RA_W-1:0] pend_rd_q, pend_rd_d;
  logic            pend_we_q, pend_we_d;
  logic [2:0]      pend_f3_q, pend_f3_d;
  logic [2:0]      pend_lo_q, pend_lo_d;
  logic            rf_we_q;
  logic [RA_W-1:0] rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;

  logic            wr_en;
  logic [RA_W-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            accept;
  logic            is_load;

  // Extract the addressed lane and extend it; misaligned offsets are truncated
  // down to the access alignment. Done at 64 bits and trimmed to XLEN.
  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                               input logic [2:0] lo,
                                               input logic [XLEN-1:0] data);
    logic [63:0] d64;
    logic [63:0] sh;
    logic [63:0] r;
    logic [2:0]  off;
    d64 = 64'(data);
    off = lo & LANE_MASK;
    case (f3[1:0])
      2'b00:   off = off;
      2'b01:   off = {off[2:1], 1'b0};
      2'b10:   off = {off[2], 2'b00};
      default: off = 3'b000;
    endcase
    sh = d64 >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{56{sh[7]}}, sh[7:0]};
      3'b100:  r = {56'd0, sh[7:0]};
      3'b001:  r = {{48{sh[15]}}, sh[15:0]};
      3'b101:  r = {48'd0, sh[15:0]};
      3'b010:  r = {{32{sh[31]}}, sh[31:0]};
      3'b110:  r = {32'd0, sh[31:0]};
      default: r = d64;
    endcase
    return r[XLEN-1:0];
  endfunction

  assign wb.in_ready = (state_q == IDLE);
  assign wb.busy     = (state_q == WAIT_MEM);
  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;

  assign accept  = wb.in_valid && (state_q == IDLE) && !wb.flush;
  assign is_load = (wb.in_sel == 2'b01);

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    pend_we_d = pend_we_q;
    pend_f3_d = pend_f3_q;
    pend_lo_d = pend_lo_q;
    wr_en     = 1'b0;
    wr_addr   = wb.in_rd;
    wr_data   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_load) begin
            wr_en = wb.in_we && (wb.in_rd != '0);
            case (wb.in_sel)
              2'b00:   wr_data = wb.in_alu;
              2'b10:   wr_data = wb.in_pc4;
              default: wr_data = wb.in_imm;
            endcase
          end else if (wb.mem_rsp_valid) begin
            wr_en   = wb.in_we && (wb.in_rd != '0);
            wr_data = fmt_load(wb.in_funct3, wb.in_addr_lo, wb.mem_rsp_data);
          end else begin
            pend_rd_d = wb.in_rd;
            pend_we_d = wb.in_we;
            pend_f3_d = wb.in_funct3;
            pend_lo_d = wb.in_addr_lo;
            state_d   = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        // Flush wins over a coincident response: the load is dropped.
        if (wb.flush) begin
          state_d = IDLE;
        end else if (wb.mem_rsp_valid) begin
          wr_en   = pend_we_q && (pend_rd_q != '0);
          wr_addr = pend_rd_q;
          wr_data = fmt_load(pend_f3_q, pend_lo_q, wb.mem_rsp_data);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      pend_we_q  <= 1'b0;
      pend_f3_q  <= 3'b000;
      pend_lo_q  <= 3'b000;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_we_q <= pend_we_d;
      pend_f3_q <= pend_f3_d;
      pend_lo_q <= pend_lo_d;
      rf_we_q   <= wr_en;
      // Address and data only move on an actual write so they hold otherwise.
      if (wr_en) begin
        rf_waddr_q <= wr_addr;
        rf_wdata_q <= wr_data;
      end
    end
  end
endmodule
